// File: rtl/waveform_comb.sv
// waveform_comb: merges two oscillator voice sample streams into one 8-bit
// waveform. Single mode forwards voice 1. Multi mode pairs one sample from
// each voice and outputs their floored average.
//
// Output handshake: `ready` is a one-cycle valid strobe that accompanies each
// new `comb_waveform` value. There is no ready/backpressure input, so the
// consumer must take the value in the cycle `ready` is high. `comb_waveform`
// holds its value between strobes.
module waveform_comb (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       multi,
  input  logic       done1,
  input  logic       done2,
  input  logic [7:0] sample1,
  input  logic [7:0] sample2,
  output logic       ready,
  output logic [7:0] comb_waveform
);

  logic       done1_q, done2_q, multi_q;
  logic       got1_q, got1_d, got2_q, got2_d;
  logic [7:0] hold1_q, hold1_d, hold2_q, hold2_d;
  logic [7:0] wave_q, wave_d;
  logic       ready_q, ready_d;

  logic       rise1, rise2, mode_chg;
  logic       have1, have2;
  logic [7:0] a, b;
  logic [8:0] sum;

  // Edge detection; a held `done` produces a single event.
  assign rise1    = done1 & ~done1_q;
  assign rise2    = done2 & ~done2_q;
  // A mode change discards any half-collected pair.
  assign mode_chg = multi ^ multi_q;

  // Pair state seen after this cycle's events (pending flags survive only
  // if the mode is stable).
  assign have1 = (got1_q & ~mode_chg) | rise1;
  assign have2 = (got2_q & ~mode_chg) | rise2;

  // Operands: a fresh sample this cycle wins over the held one.
  assign a   = rise1 ? sample1 : hold1_q;
  assign b   = rise2 ? sample2 : hold2_q;
  assign sum = {1'b0, a} + {1'b0, b};

  // Next-state logic for pairing, holding registers and the output value.
  always_comb begin
    got1_d  = 1'b0;
    got2_d  = 1'b0;
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    wave_d  = wave_q;
    ready_d = 1'b0;
    if (!multi) begin
      // Voice 2 is ignored entirely in single mode.
      if (rise1) begin
        wave_d  = sample1;
        ready_d = 1'b1;
      end
    end else begin
      if (rise1) hold1_d = sample1;
      if (rise2) hold2_d = sample2;
      if (have1 && have2) begin
        wave_d  = sum[8:1];
        ready_d = 1'b1;
      end else begin
        got1_d = have1;
        got2_d = have2;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      done1_q <= 1'b0;
      done2_q <= 1'b0;
      multi_q <= 1'b0;
      got1_q  <= 1'b0;
      got2_q  <= 1'b0;
      hold1_q <= 8'd0;
      hold2_q <= 8'd0;
      wave_q  <= 8'd0;
      ready_q <= 1'b0;
    end else begin
      done1_q <= done1;
      done2_q <= done2;
      multi_q <= multi;
      got1_q  <= got1_d;
      got2_q  <= got2_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
      wave_q  <= wave_d;
      ready_q <= ready_d;
    end
  end

  assign ready         = ready_q;
  assign comb_waveform = wave_q;

endmodule

// File: tb/tb_waveform_comb.sv
// Directed bench for waveform_comb: reset, single pass-through, multi-voice
// averaging, boundaries, overwrite, mode switch and reset mid-pair.
module tb_waveform_comb;

  logic       clk;
  logic       n_rst;
  logic       multi;
  logic       done1;
  logic       done2;
  logic [7:0] sample1;
  logic [7:0] sample2;
  logic       ready;
  logic [7:0] comb_waveform;

  int n_cmp;
  int n_bad;

  waveform_comb dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .multi        (multi),
    .done1        (done1),
    .done2        (done2),
    .sample1      (sample1),
    .sample2      (sample2),
    .ready        (ready),
    .comb_waveform(comb_waveform)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs of that edge are visible.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst   = 1'b0;
    multi   = 1'($urandom_range(0, 1));
    done1   = 1'($urandom_range(0, 1));
    done2   = 1'($urandom_range(0, 1));
    sample1 = 8'($urandom_range(0, 255));
    sample2 = 8'($urandom_range(0, 255));
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (comb_waveform !== 8'd0) begin
        n_bad++; $display("FAIL reset_wave: got %0d expected 0", comb_waveform);
      end
      n_cmp++;
      if (ready !== 1'b0) begin
        n_bad++; $display("FAIL reset_ready: got %b expected 0", ready);
      end
    end
    multi = 1'b0; done1 = 1'b0; done2 = 1'b0;
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (ready !== 1'b0 || comb_waveform !== 8'd0) begin
        n_bad++;
        $display("FAIL post_reset_idle: got ready=%b wave=%0d expected ready=0 wave=0", ready, comb_waveform);
      end
    end
  endtask

  task automatic test_single();
    multi = 1'b0; sample1 = 8'd142; done1 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b1 || comb_waveform !== 8'd142) begin
      n_bad++;
      $display("FAIL single_pass: got ready=%b wave=%0d expected ready=1 wave=142", ready, comb_waveform);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (ready !== 1'b0 || comb_waveform !== 8'd142) begin
        n_bad++;
        $display("FAIL single_held: got ready=%b wave=%0d expected ready=0 wave=142", ready, comb_waveform);
      end
    end
    done1 = 1'b0;
    tick();
    sample2 = 8'd243; done2 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b0 || comb_waveform !== 8'd142) begin
      n_bad++;
      $display("FAIL single_ignore_v2: got ready=%b wave=%0d expected ready=0 wave=142", ready, comb_waveform);
    end
    done2 = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL single_ignore_v2_after: got %b expected 0", ready);
    end
  endtask

  task automatic test_multi_staggered();
    multi = 1'b1;
    tick();
    sample1 = 8'd203; done1 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL stagger_early: got %b expected 0", ready);
    end
    done1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (ready !== 1'b0) begin
        n_bad++; $display("FAIL stagger_wait: got %b expected 0", ready);
      end
    end
    sample2 = 8'd243; done2 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b1 || comb_waveform !== 8'd223) begin
      n_bad++;
      $display("FAIL stagger_avg: got ready=%b wave=%0d expected ready=1 wave=223", ready, comb_waveform);
    end
    done2 = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b0 || comb_waveform !== 8'd223) begin
      n_bad++;
      $display("FAIL stagger_after: got ready=%b wave=%0d expected ready=0 wave=223", ready, comb_waveform);
    end
  endtask

  task automatic test_simultaneous();
    sample1 = 8'd255; sample2 = 8'd255; done1 = 1'b1; done2 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b1 || comb_waveform !== 8'd255) begin
      n_bad++;
      $display("FAIL simul_max: got ready=%b wave=%0d expected ready=1 wave=255", ready, comb_waveform);
    end
    done1 = 1'b0; done2 = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL simul_max_once: got %b expected 0", ready);
    end
    sample1 = 8'd0; sample2 = 8'd1; done1 = 1'b1; done2 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b1 || comb_waveform !== 8'd0) begin
      n_bad++;
      $display("FAIL simul_floor: got ready=%b wave=%0d expected ready=1 wave=0", ready, comb_waveform);
    end
    done1 = 1'b0; done2 = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL simul_floor_once: got %b expected 0", ready);
    end
  endtask

  task automatic test_overwrite();
    sample1 = 8'd10; done1 = 1'b1;
    tick();
    done1 = 1'b0;
    tick();
    sample1 = 8'd50; done1 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL overwrite_no_early: got %b expected 0", ready);
    end
    done1 = 1'b0;
    tick();
    sample2 = 8'd70; done2 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b1 || comb_waveform !== 8'd60) begin
      n_bad++;
      $display("FAIL overwrite_avg: got ready=%b wave=%0d expected ready=1 wave=60", ready, comb_waveform);
    end
    done2 = 1'b0;
    tick();
  endtask

  task automatic test_mode_switch();
    sample1 = 8'd100; done1 = 1'b1;
    tick();
    done1 = 1'b0; multi = 1'b0;
    tick();
    multi = 1'b1;
    tick();
    sample2 = 8'd20; done2 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b0 || comb_waveform !== 8'd60) begin
      n_bad++;
      $display("FAIL mode_clear: got ready=%b wave=%0d expected ready=0 wave=60", ready, comb_waveform);
    end
    done2 = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL mode_clear_after: got %b expected 0", ready);
    end
    // Discard the pending voice-2 sample before the next scenario.
    multi = 1'b0;
    tick();
    multi = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_pair();
    sample1 = 8'd80; done1 = 1'b1;
    tick();
    done1 = 1'b0;
    tick();
    n_rst = 1'b0;
    #2;
    n_cmp++;
    if (comb_waveform !== 8'd0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midpair_async: got ready=%b wave=%0d expected ready=0 wave=0", ready, comb_waveform);
    end
    tick();
    n_rst = 1'b1;
    tick();
    sample2 = 8'd40; done2 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b0 || comb_waveform !== 8'd0) begin
      n_bad++;
      $display("FAIL midpair_discard: got ready=%b wave=%0d expected ready=0 wave=0", ready, comb_waveform);
    end
    done2 = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b0 || comb_waveform !== 8'd0) begin
      n_bad++;
      $display("FAIL midpair_wait: got ready=%b wave=%0d expected ready=0 wave=0", ready, comb_waveform);
    end
    sample1 = 8'd100; done1 = 1'b1;
    tick();
    n_cmp++;
    if (ready !== 1'b1 || comb_waveform !== 8'd70) begin
      n_bad++;
      $display("FAIL midpair_fresh: got ready=%b wave=%0d expected ready=1 wave=70", ready, comb_waveform);
    end
    done1 = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL midpair_fresh_once: got %b expected 0", ready);
    end
  endtask

  // Main sequence
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_multi_staggered();
    test_simultaneous();
    test_overwrite();
    test_mode_switch();
    test_reset_mid_pair();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/waveform_comb.md
# waveform_comb

Combines the sample streams of two oscillator voices into the single 8-bit waveform sent to the audio output stage. In single-voice mode it passes voice 1 through. In multi-voice mode it waits until both voices have delivered a new sample, then outputs their average. Each new output value is flagged with a one-cycle `ready` strobe for the downstream consumer.

## Interface
- No parameters; all widths fixed at 8 bits.
- `clk` input 1 — system clock; all state updates on rising edge.
- `n_rst` input 1 — reset; asynchronous, active-low.
- `multi` input 1 — mode select: 0 = single voice (voice 1 only), 1 = two-voice average.
- `done1` input 1 — voice 1 sample-valid; a rising edge marks a new `sample1`.
- `done2` input 1 — voice 2 sample-valid; a rising edge marks a new `sample2`.
- `sample1` input 8 — voice 1 sample, unsigned.
- `sample2` input 8 — voice 2 sample, unsigned.
- `ready` output 1 — one-cycle strobe: `comb_waveform` has just been updated.
- `comb_waveform` output 8 — combined waveform, unsigned, registered.

## Operation
- Edge detection:
  - Registers `done1_q` and `done2_q` hold the previous-cycle values of `done1` and `done2`.
  - `rise1 = done1 & ~done1_q`; `rise2 = done2 & ~done2_q`.
  - A `done` held high produces exactly one event.
- Single mode (`multi`=0):
  - On `rise1`, `comb_waveform <= sample1` and `ready <= 1`.
  - `done2` and `sample2` are ignored.
- Multi mode (`multi`=1), pending flags `got1`/`got2` with holding registers `hold1`/`hold2`:
  - On `rise1` alone: `hold1 <= sample1` and `got1 <= 1`. Voice 2 is handled symmetrically.
  - When a sample arrives on `rise1` while `got1` is already set, it overwrites `hold1` (latest sample wins).
  - Completion occurs when, after the cycle's events, both voices have a sample:
    - `comb_waveform <= (a + b) >> 1`, using a 9-bit sum floored to 8 bits.
    - `a` is `sample1` if `rise1` this cycle, else `hold1`; `b` is chosen the same way from `sample2`/`hold2`.
    - `ready <= 1`, and `got1` and `got2` are cleared.
  - `rise1` and `rise2` in the same cycle, with both flags clear, complete immediately using `sample1` and `sample2`.
  - Neither the average nor the sum can overflow.
- Mode change:
  - Any cycle where `multi` differs from its registered previous value `multi_q` clears `got1` and `got2`.
  - A `rise1` in that same cycle is still processed under the new mode.
- `comb_waveform` holds its value between updates.
- `ready` is 0 in every cycle without an update.

## Timing
- Reset (`n_rst`=0, asynchronous) clears `comb_waveform`, `ready`, `hold1`, `hold2`, `got1`, `got2`, `done1_q`, `done2_q` and `multi_q` to 0.
- Reset asserted mid-operation discards any pending partial pair.
- Latency:
  - Output registers update on the same rising edge at which the completing rise is sampled.
  - `ready` is high for exactly the one cycle following that edge.
- Back-to-back:
  - A new completion one cycle after the previous one is legal.
  - `ready` then stays high for consecutive cycles, one cycle per update.
- Because `done1_q` resets to 0, a `done1` already high at reset release counts as a rise on the first clock edge. The same applies to `done2`.
- No backpressure: the consumer must accept the value while `ready` is high.

## Test plan
- Reset:
  - Stimulus: assert `n_rst`=0 with random inputs, then release.
  - Required: `comb_waveform`=0 and `ready`=0 while in reset; no spurious `ready` afterwards while `done1`/`done2` stay 0.
- Single pass-through:
  - Stimulus: `multi`=0, `sample1`=142, raise `done1` and hold it high for 3 cycles.
  - Required: `comb_waveform`=142 one edge later, a single `ready` pulse, no further pulses.
  - Stimulus: pulse `done2` with `sample2`=243.
  - Required: no change to `comb_waveform`, no `ready`.
- Multi average, staggered:
  - Stimulus: `multi`=1; `rise1` with `sample1`=203; `rise2` 3 cycles later with `sample2`=243.
  - Required: `ready` only after `rise2`, with `comb_waveform`=223.
- Multi simultaneous and boundary:
  - Stimulus: `rise1` and `rise2` in the same cycle with 255/255. Required: `comb_waveform`=255.
  - Stimulus: `rise1` and `rise2` in the same cycle with 0/1. Required: `comb_waveform`=0.
  - Each case produces one `ready` pulse.
- Overwrite and mode switch:
  - Stimulus: `multi`=1; `rise1` with 10, `rise1` with 50, then `rise2` with 70. Required: `comb_waveform`=60.
  - Stimulus: `rise1` with 100, toggle `multi` to 0 and back to 1, then `rise2` with 20. Required: no `ready`; the pair stays incomplete.
- Reset mid-pair:
  - Stimulus: `multi`=1, `rise1` with 80, pulse `n_rst` low, then `rise2` with 40.
  - Required: no `ready` and `comb_waveform`=0 until a fresh `rise1` arrives.
